systolic_seq_ctrl: RTL and testbench

SYSTOLIC_SEQ_CTRL -- requirements
Module: systolic_seq_ctrl

---
 rtl/systolic_seq_ctrl_pkg.sv | 18 +
 rtl/seq_tag_pipe.sv | 53 +++++
 rtl/systolic_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and defaults for the systolic array sequencing controller.
//   state_e    : controller state encoding (2 bits)
//   DEF_STAGES : default array depth between arr_data and arr_out
//   DEF_WIDTH  : default lane width
//   CNT_MAX    : saturation value of the per-burst word counter
package systolic_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int unsigned DEF_STAGES = 16;
   localparam int unsigned DEF_WIDTH  = 8;
   localparam logic [7:0]  CNT_MAX    = 8'd255;

endpackage

// File: rtl/seq_tag_pipe.sv
// Valid/last tag shift register kept in lock-step with the external array.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   shift_en     : advance all tags one stage (same enable as the array)
//   vld_in       : valid tag entering stage 0
//   lst_in       : last tag entering stage 0
//   vld_tail     : valid tag at the final stage
//   lst_tail     : last tag at the final stage
//   any_vld_nxt  : some stage will hold a valid word after this cycle's update
module seq_tag_pipe
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int unsigned STAGES = DEF_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic shift_en,
   input  logic vld_in,
   input  logic lst_in,
   output logic vld_tail,
   output logic lst_tail,
   output logic any_vld_nxt
);

   logic [STAGES-1:0] vld_q, vld_d;
   logic [STAGES-1:0] lst_q, lst_d;

   always_comb begin
      vld_d = vld_q;
      lst_d = lst_q;
      if (shift_en) begin
         vld_d = {vld_q[STAGES-2:0], vld_in};
         lst_d = {lst_q[STAGES-2:0], lst_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         lst_q <= '0;
      end else begin
         vld_q <= vld_d;
         lst_q <= lst_d;
      end
   end

   assign vld_tail    = vld_q[STAGES-1];
   assign lst_tail    = lst_q[STAGES-1];
   // Looks at the post-shift vector so DRAIN can leave the cycle the last
   // valid word is handed off.
   assign any_vld_nxt = |vld_d;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencing controller for an external STAGES-deep systolic shift array.
// Feeds upstream words into the array, tracks which array slots hold real
// words, drains bubbles after the last word of a burst and stalls the whole
// array on downstream backpressure.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no burst open; first accepted word opens one
// ST_FILL  | burst open, array advances only on accepted words
// ST_DRAIN | last word taken; bubbles pushed in until no valid word left
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready     : upstream word handshake
//   arr_shift_en/arr_data/arr_out         : array enable, head word, tail word
//   out_valid/out_data/out_last/out_ready : downstream word handshake
//   busy                : controller not idle
//   burst_len           : accepted-word count of last completed burst (sat. 255)
module systolic_seq_ctrl
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int unsigned STAGES = DEF_STAGES,
   parameter int unsigned WIDTH  = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             arr_shift_en,
   output logic [WIDTH-1:0] arr_data,
   input  logic [WIDTH-1:0] arr_out,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic [7:0]       burst_len
);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] burst_len_q, burst_len_d;
   logic [7:0] cnt_inc;

   logic vld_tail, lst_tail, any_vld_nxt;
   logic tail_free, accept;

   // The tail can move when it holds a bubble or the downstream takes it.
   assign tail_free    = !vld_tail | out_ready;
   assign in_ready     = tail_free & (state_q != ST_DRAIN);
   assign accept       = in_valid & in_ready;
   assign arr_shift_en = accept | ((state_q == ST_DRAIN) & tail_free);
   assign arr_data     = accept ? in_data : '0;

   assign out_valid = vld_tail;
   assign out_last  = lst_tail & vld_tail;
   assign out_data  = arr_out;
   assign busy      = (state_q != ST_IDLE);
   assign burst_len = burst_len_q;

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;

   seq_tag_pipe #(
      .STAGES (STAGES)
   ) u_tag_pipe (
      .clk         (clk),
      .rst         (rst),
      .shift_en    (arr_shift_en),
      .vld_in      (accept),
      .lst_in      (accept & in_last),
      .vld_tail    (vld_tail),
      .lst_tail    (lst_tail),
      .any_vld_nxt (any_vld_nxt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      burst_len_d = burst_len_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // Count restarts with the opening word already included.
               cnt_d = 8'd1;
               if (in_last) begin
                  state_d     = ST_DRAIN;
                  burst_len_d = 8'd1;
               end else begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (accept) begin
               cnt_d = cnt_inc;
               if (in_last) begin
                  state_d     = ST_DRAIN;
                  burst_len_d = cnt_inc;
               end
            end
         end
         ST_DRAIN: begin
            if (!any_vld_nxt) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         burst_len_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         burst_len_q <= burst_len_d;
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl with a behavioural model of the
// external shift array (enable-gated, never cleared).
module tb_systolic_seq_ctrl;

   localparam int STAGES = 16;
   localparam int WIDTH  = 8;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
      int               cyc;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic             arr_shift_en;
   logic [WIDTH-1:0] arr_data;
   logic [WIDTH-1:0] arr_out;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready = 1'b1;
   logic             busy;
   logic [7:0]       burst_len;

   logic [WIDTH-1:0] arr_m [STAGES];

   ent_t tx_q[$];
   ent_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;
   int   cyc      = 0;
   bit   lat_mode = 1'b1;

   systolic_seq_ctrl #(
      .STAGES (STAGES),
      .WIDTH  (WIDTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .arr_shift_en (arr_shift_en),
      .arr_data     (arr_data),
      .arr_out      (arr_out),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_ready    (out_ready),
      .busy         (busy),
      .burst_len    (burst_len)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Array model.
   always @(posedge clk) begin
      if (arr_shift_en) begin
         for (int i = STAGES - 1; i > 0; i--) arr_m[i] <= arr_m[i-1];
         arr_m[0] <= arr_data;
      end
   end
   assign arr_out = arr_m[STAGES-1];

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] d, input logic l);
      ent_t e;
      e.data = d;
      e.last = l;
      e.cyc  = 0;
      tx_q.push_back(e);
   endtask

   // Driver: presents the head of tx_q just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (tx_q.size() > 0) begin
         in_valid = 1'b1;
         in_data  = tx_q[0].data;
         in_last  = tx_q[0].last;
      end else begin
         in_valid = 1'b0;
         in_data  = '0;
         in_last  = 1'b0;
      end
   end

   // Monitor / scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      ent_t e;
      if (!rst) begin
         if (!out_valid) chk("last_without_valid", int'(out_last), 0);
         if (out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
               chk("unexpected_out", int'(out_data), -1);
            end else begin
               e = sb_q.pop_front();
               chk("out_data", int'(out_data), int'(e.data));
               chk("out_last", int'(out_last), int'(e.last));
               if (lat_mode) chk("latency", cyc - e.cyc, STAGES);
            end
         end
         if (in_valid && in_ready) begin
            e.data = in_data;
            e.last = in_last;
            e.cyc  = cyc;
            sb_q.push_back(e);
            if (tx_q.size() > 0) void'(tx_q.pop_front());
         end
      end
   end

   task automatic wait_idle(input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(negedge clk);
         if (tx_q.size() == 0 && sb_q.size() == 0 && !busy) break;
      end
      chk("idle_within_budget", int'(i < max), 1);
   endtask

   initial begin
      int i;
      int n0;

      // Reset.
      rst       = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_shift_en", int'(arr_shift_en), 0);
      chk("rst_burst_len", int'(burst_len), 0);

      // Three-word burst, no backpressure.
      n0 = n_out;
      push_word(8'h11, 1'b0);
      push_word(8'h22, 1'b0);
      push_word(8'h33, 1'b1);
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid && out_last) break;
      end
      chk("burst3_last_seen", int'(i < 60), 1);
      chk("burst3_busy_at_last", int'(busy), 1);
      @(negedge clk);
      chk("burst3_busy_after", int'(busy), 0);
      chk("burst3_len", int'(burst_len), 3);
      chk("burst3_count", n_out - n0, 3);

      // Single word with last goes straight to DRAIN.
      push_word(8'hA5, 1'b1);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_valid && in_ready) break;
      end
      chk("single_accepted", int'(i < 20), 1);
      @(negedge clk);
      chk("single_drain_in_ready", int'(in_ready), 0);
      chk("single_drain_busy", int'(busy), 1);
      wait_idle(60);
      chk("single_len", int'(burst_len), 1);

      // Backpressure: stall the tail for 5 cycles mid-burst.
      lat_mode = 1'b0;
      n0 = n_out;
      for (int k = 0; k < 20; k++) push_word(8'(8'h40 + k), k == 19);
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("bp_first_out", int'(i < 60), 1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_shift_en", int'(arr_shift_en), 0);
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_in_valid_pending", int'(in_valid), 1);
         if (sb_q.size() > 0) chk("bp_out_data_held", int'(out_data), int'(sb_q[0].data));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle(120);
      chk("bp_count", n_out - n0, 20);
      chk("bp_len", int'(burst_len), 20);
      lat_mode = 1'b1;

      // Reset during DRAIN with words in flight.
      push_word(8'hC1, 1'b0);
      push_word(8'hC2, 1'b0);
      push_word(8'hC3, 1'b0);
      push_word(8'hC4, 1'b1);
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy && !in_ready) break;
      end
      chk("mid_drain_reached", int'(i < 20), 1);
      @(posedge clk);
      #1;
      tx_q.delete();
      sb_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_len", int'(burst_len), 0);
      n0 = n_out;
      push_word(8'h5A, 1'b1);
      wait_idle(60);
      repeat (STAGES + 2) @(negedge clk);
      chk("post_rst_count", n_out - n0, 1);

      // Long burst: counter saturates.
      n0 = n_out;
      for (int k = 0; k < 300; k++) push_word(8'(k * 7 + 3), k == 299);
      wait_idle(800);
      chk("long_count", n_out - n0, 300);
      chk("long_len_sat", int'(burst_len), 255);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
